// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// Merges single-cycle ALU results (highest priority) with long-latency results
// that wait in a small FIFO. The module drives the single registered write port
// and provides per-register busy flags to decode.
//
// Handshake (long-latency input): a transfer happens on a rising clock edge
// when lu_valid && lu_ready. The producer holds lu_reg/lu_data stable while
// lu_valid is high and the transfer has not yet happened. lu_ready is !full.
// Because lu_ready depends only on occupancy, a full FIFO refuses input even
// when an entry pops in the same cycle. The ALU input has no back-pressure, so
// an ALU result is taken in every cycle that alu_valid is high.
module regfile_write_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       alu_valid,
   input  logic [ADDR_W-1:0]          alu_reg,
   input  logic [DATA_W-1:0]          alu_data,
   input  logic                       lu_valid,
   output logic                       lu_ready,
   input  logic [ADDR_W-1:0]          lu_reg,
   input  logic [DATA_W-1:0]          lu_data,
   output logic                       RegWrite,
   output logic [ADDR_W-1:0]          wreg,
   output logic [DATA_W-1:0]          wdata,
   input  logic [ADDR_W-1:0]          q_reg1,
   input  logic [ADDR_W-1:0]          q_reg2,
   output logic                       busy1,
   output logic                       busy2,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // FIFO storage. A kill bit marks an entry superseded by a younger ALU
   // write to the same register; it still drains in order but writes nothing.
   logic [ADDR_W-1:0] ent_reg  [DEPTH];
   logic [DATA_W-1:0] ent_data [DEPTH];
   logic [DEPTH-1:0]  ent_kill;
   logic [DEPTH-1:0]  ent_occ;

   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;

   logic push;       // handshake completes this cycle
   logic pop;        // head entry is issued this cycle
   logic bypass;     // pushed entry goes straight to the write port
   logic store;      // pushed entry is written into the FIFO
   logic push_kill;  // pushed entry is already superseded by the ALU result

   assign full     = (count == DEPTH_C);
   assign empty    = (count == '0);
   assign lu_ready = !full;

   // Issue priority and push routing for this cycle.
   always_comb begin
      push      = lu_valid && lu_ready;
      pop       = !alu_valid && !empty;
      bypass    = !alu_valid && empty && push;
      store     = push && !bypass;
      push_kill = alu_valid && (lu_reg == alu_reg);
   end

   // Occupancy per slot, derived from head and count (slot offset from head
   // below count means the slot holds an entry).
   always_comb begin
      ent_occ = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_occ[i] = ({1'b0, PTR_W'(PTR_W'(i) - head)} < count);
      end
   end

   // Busy flags: only occupied, unkilled entries count as pending writes.
   always_comb begin
      busy1 = 1'b0;
      busy2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_occ[i] && !ent_kill[i]) begin
            if (ent_reg[i] == q_reg1) busy1 = 1'b1;
            if (ent_reg[i] == q_reg2) busy2 = 1'b1;
         end
      end
   end

   // Payload storage; contents are only meaningful while the slot is occupied.
   always_ff @(posedge clk) begin
      if (store) begin
         ent_reg[tail]  <= lu_reg;
         ent_data[tail] <= lu_data;
      end
   end

   // Kill bits: set on stored entries matching an ALU write, cleared on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_kill <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (store && (tail == PTR_W'(i))) begin
               ent_kill[i] <= push_kill;
            end else if (alu_valid && ent_occ[i] && (ent_reg[i] == alu_reg)) begin
               ent_kill[i] <= 1'b1;
            end
         end
      end
   end

   // Pointers and occupancy count; pointers wrap naturally as DEPTH is 2^n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (store) tail <= tail + PTR_W'(1);
         if (pop)   head <= head + PTR_W'(1);
         case ({store, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Registered write port: ALU first, then FIFO head, then bypass, else idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWrite <= 1'b0;
         wreg     <= '0;
         wdata    <= '0;
      end else if (alu_valid) begin
         RegWrite <= 1'b1;
         wreg     <= alu_reg;
         wdata    <= alu_data;
      end else if (!empty) begin
         RegWrite <= !ent_kill[head];
         wreg     <= ent_reg[head];
         wdata    <= ent_data[head];
      end else if (bypass) begin
         RegWrite <= 1'b1;
         wreg     <= lu_reg;
         wdata    <= lu_data;
      end else begin
         RegWrite <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: write-port scoreboard, register-file model,
// table-driven fill/drain sequence and hand-written corner sequences.
module tb_regfile_write_arbiter;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 3;

   logic              clk;
   logic              rst_n;
   logic              alu_valid;
   logic [ADDR_W-1:0] alu_reg;
   logic [DATA_W-1:0] alu_data;
   logic              lu_valid;
   logic              lu_ready;
   logic [ADDR_W-1:0] lu_reg;
   logic [DATA_W-1:0] lu_data;
   logic              RegWrite;
   logic [ADDR_W-1:0] wreg;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] q_reg1;
   logic [ADDR_W-1:0] q_reg2;
   logic              busy1;
   logic              busy2;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;

   regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_reg(lu_reg), .lu_data(lu_data),
      .RegWrite(RegWrite), .wreg(wreg), .wdata(wdata),
      .q_reg1(q_reg1), .q_reg2(q_reg2), .busy1(busy1), .busy2(busy2),
      .count(count), .full(full), .empty(empty)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_cmp = 0;
   int n_bad = 0;
   logic [ADDR_W+DATA_W-1:0] exp_q[$];
   logic [ADDR_W+DATA_W-1:0] lq[$];
   logic [DATA_W-1:0] rf [32];
   logic [31:0]       rf_wr = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Register file model and scoreboard: samples the write port at negedge.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && RegWrite === 1'b1) begin
         logic [ADDR_W+DATA_W-1:0] e;
         rf[wreg] = wdata;
         rf_wr[wreg] = 1'b1;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write: got reg %0d data %0h, want no write", wreg, wdata);
         end else begin
            e = exp_q.pop_front();
            if ({wreg, wdata} !== e) begin
               n_bad++;
               $display("FAIL write_order: got reg %0d data %0h, want reg %0d data %0h",
                        wreg, wdata, e[DATA_W+:ADDR_W], e[DATA_W-1:0]);
            end
         end
      end
   end

   // Driver tasks
   task automatic drive(input logic av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                        input logic lv, input logic [ADDR_W-1:0] lr, input logic [DATA_W-1:0] ld);
      alu_valid = av; alu_reg = ar; alu_data = ad;
      lu_valid  = lv; lu_reg  = lr; lu_data  = ld;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic              av;
      logic [ADDR_W-1:0] ar;
      logic [DATA_W-1:0] ad;
      logic              lv;
      logic [ADDR_W-1:0] lr;
      logic [DATA_W-1:0] ld;
      logic [ADDR_W-1:0] q1;
      logic              rw;
      logic [ADDR_W-1:0] wr;
      logic [DATA_W-1:0] wd;
      logic [CNT_W-1:0]  cnt;
      logic              fl;
      logic              rdy;
      logic              bsy;
   } vec_t;

   function automatic vec_t mk(input logic av, input int ar, input int ad,
                               input logic lv, input int lr, input int ld, input int q1,
                               input logic rw, input int wr, input int wd,
                               input int cnt, input logic fl, input logic rdy, input logic bsy);
      vec_t v;
      v.av = av; v.ar = ADDR_W'(ar); v.ad = DATA_W'(ad);
      v.lv = lv; v.lr = ADDR_W'(lr); v.ld = DATA_W'(ld);
      v.q1 = ADDR_W'(q1);
      v.rw = rw; v.wr = ADDR_W'(wr); v.wd = DATA_W'(wd);
      v.cnt = CNT_W'(cnt); v.fl = fl; v.rdy = rdy; v.bsy = bsy;
      return v;
   endfunction

   vec_t tbl[11];

   initial begin
      // Priority/fill/drain table: outputs expected just after each edge.
      tbl[0]  = mk(1, 1, 'h10, 1,  8, 'h80,  8, 1,  1, 'h10, 1, 0, 1, 1);
      tbl[1]  = mk(1, 2, 'h11, 1,  9, 'h81,  9, 1,  2, 'h11, 2, 0, 1, 1);
      tbl[2]  = mk(1, 3, 'h12, 1, 10, 'h82, 10, 1,  3, 'h12, 3, 0, 1, 1);
      tbl[3]  = mk(1, 4, 'h13, 1, 11, 'h83, 11, 1,  4, 'h13, 4, 1, 0, 1);
      tbl[4]  = mk(1, 5, 'h14, 1, 12, 'h84, 12, 1,  5, 'h14, 4, 1, 0, 0);
      tbl[5]  = mk(1, 6, 'h15, 0,  0,    0,  8, 1,  6, 'h15, 4, 1, 0, 1);
      tbl[6]  = mk(0, 0,    0, 0,  0,    0,  8, 1,  8, 'h80, 3, 0, 1, 0);
      tbl[7]  = mk(0, 0,    0, 0,  0,    0,  9, 1,  9, 'h81, 2, 0, 1, 0);
      tbl[8]  = mk(0, 0,    0, 0,  0,    0, 11, 1, 10, 'h82, 1, 0, 1, 1);
      tbl[9]  = mk(0, 0,    0, 0,  0,    0, 11, 1, 11, 'h83, 0, 0, 1, 0);
      tbl[10] = mk(0, 0,    0, 0,  0,    0,  0, 0, 11, 'h83, 0, 0, 1, 0);

      // Reset and idle
      rst_n = 1'b0;
      idle();
      q_reg1 = '0;
      q_reg2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {RegWrite, wreg, wdata, count, empty, full, lu_ready},
            {1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b1});
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle", {RegWrite, empty, lu_ready, busy1, busy2}, 5'b01100);
      end

      // Bypass into an empty FIFO
      drive(1'b0, '0, '0, 1'b1, 5'd7, 32'h0000_00A5);
      q_reg1 = 5'd7;
      #1;
      check("bypass_ready", {31'd0, lu_ready}, 1);
      exp_q.push_back({5'd7, 32'h0000_00A5});
      tick();
      check("bypass_out", {RegWrite, wreg, wdata}, {1'b1, 5'd7, 32'h0000_00A5});
      check("bypass_status", {count, busy1, empty}, {3'd0, 1'b0, 1'b1});
      idle();
      tick();
      check("bypass_rf", rf[7], 32'h0000_00A5);

      // Table: ALU priority while the FIFO fills, then drain
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].lv, tbl[i].lr, tbl[i].ld);
         q_reg1 = tbl[i].q1;
         if (tbl[i].rw) exp_q.push_back({tbl[i].wr, tbl[i].wd});
         tick();
         check($sformatf("tbl%0d_out", i), {RegWrite, wreg, wdata}, {tbl[i].rw, tbl[i].wr, tbl[i].wd});
         check($sformatf("tbl%0d_status", i), {count, full, empty, lu_ready, busy1},
               {tbl[i].cnt, tbl[i].fl, (tbl[i].cnt == 0), tbl[i].rdy, tbl[i].bsy});
      end
      idle();

      // Kill: queued write to r3 superseded by a younger ALU write
      drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd3, 32'h111);
      q_reg1 = 5'd3;
      exp_q.push_back({5'd20, 32'h20});
      tick();
      check("kill_queued", {count, busy1}, {3'd1, 1'b1});
      drive(1'b1, 5'd3, 32'h222, 1'b0, '0, '0);
      exp_q.push_back({5'd3, 32'h222});
      tick();
      check("kill_alu_out", {RegWrite, wreg, wdata}, {1'b1, 5'd3, 32'h222});
      check("kill_busy_drop", {count, busy1}, {3'd1, 1'b0});
      idle();
      tick();
      check("kill_pop", {RegWrite, count, empty}, {1'b0, 3'd0, 1'b1});
      tick();
      check("kill_rf", rf[3], 32'h222);

      // Same-register ALU and long-latency result in one cycle
      drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd5, 32'h66);
      q_reg1 = 5'd5;
      #1;
      check("same_ready", {31'd0, lu_ready}, 1);
      exp_q.push_back({5'd5, 32'h55});
      tick();
      check("same_out", {RegWrite, wreg, wdata}, {1'b1, 5'd5, 32'h55});
      check("same_status", {count, busy1}, {3'd1, 1'b0});
      idle();
      tick();
      check("same_pop", {RegWrite, count}, {1'b0, 3'd0});
      tick();
      check("same_rf", rf[5], 32'h55);

      // Interleaved push/pop across pointer wrap, then reset with 3 queued
      for (int i = 0; i < 9; i++) begin
         logic av;
         av = (i % 3 == 0);
         drive(av, 5'd28, DATA_W'(32'hA00 + i), 1'b1, ADDR_W'(16 + i), DATA_W'(32'h900 + i));
         if (av) exp_q.push_back({5'd28, DATA_W'(32'hA00 + i)});
         else if (lq.size() > 0) exp_q.push_back(lq.pop_front());
         lq.push_back({ADDR_W'(16 + i), DATA_W'(32'h900 + i)});
         tick();
         check($sformatf("wrap%0d_count", i), {29'd0, count}, 64'(lq.size()));
      end
      idle();
      q_reg1 = 5'd22;
      q_reg2 = 5'd23;
      @(negedge clk);
      #1;
      check("wrap_busy", {count, busy1, busy2, RegWrite}, {3'd3, 1'b1, 1'b1, 1'b1});
      rst_n = 1'b0;
      #1;
      check("midreset", {count, RegWrite, empty, full, lu_ready, busy1, busy2},
            {3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("post_reset_idle", {RegWrite, count}, {1'b0, 3'd0});
      end
      check("sb_drained", 64'(exp_q.size()), 0);
      check("discarded", {61'd0, rf_wr[24], rf_wr[23], rf_wr[22]}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Sits directly upstream of the CPU register file and drives its single write port (RegWrite, wreg, wdata).
- Merges results from two producers:
  - the single-cycle ALU path, which has priority;
  - the long-latency unit (multiply/divide/load), buffered in a DEPTH-entry FIFO with a valid/ready handshake.
- Exposes per-register busy flags so decode can detect reads of registers that still have a queued write.

Parameters:
- DATA_W, 32, result data width
- ADDR_W, 5, register index width
- DEPTH, 4, long-latency FIFO entries; must be a power of 2, ≥ 2

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result present this cycle; must be accepted, no back-pressure
- alu_reg  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  FIFO can accept; equals !full (combinational)
- lu_reg  in  ADDR_W  long-latency destination register
- lu_data  in  DATA_W  long-latency result
- RegWrite  out  1  register file write enable (registered)
- wreg  out  ADDR_W  register file write index (registered)
- wdata  out  DATA_W  register file write data (registered)
- q_reg1  in  ADDR_W  decode query index 1
- q_reg2  in  ADDR_W  decode query index 2
- busy1  out  1  live queued write pending to q_reg1 (combinational)
- busy2  out  1  live queued write pending to q_reg2 (combinational)
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - RegWrite=0, wreg=0, wdata=0.
  - FIFO pointers, count and all kill bits cleared, so empty=1, full=0, lu_ready=1, busy1=busy2=0.
  - Reset mid-operation discards all queued entries; no partial write is emitted.
- Write-port timing: outputs are registered at posedge N and the register file samples them at the following negedge. A result issued in cycle N is therefore readable from the register file after that negedge.
- Push: lu_valid && lu_ready.
  - The entry {reg, data, kill=0} is written at the tail and the tail pointer advances mod DEPTH.
  - When full, lu_ready is low even if a pop happens in the same cycle (no push-on-pop when full).
- Issue priority, evaluated once per cycle:
  1. alu_valid: RegWrite=1, wreg=alu_reg, wdata=alu_data. The FIFO does not pop.
  2. Otherwise, FIFO non-empty: pop the head. RegWrite = !head.kill, wreg/wdata from the head.
  3. Otherwise, FIFO empty and push this cycle: bypass. The pushed entry is issued directly (RegWrite=1) and not stored; count stays 0.
  4. Otherwise: RegWrite=0; wreg/wdata hold their previous values.
- Ordering rule: an ALU result is always younger than any long-latency result that is queued or arriving in the same cycle.
  - When alu_valid, every live FIFO entry with reg == alu_reg gets kill=1.
  - A simultaneous push with lu_reg == alu_reg is accepted (handshake completes) but stored with kill=1.
- Killed entries:
  - still occupy a slot and are popped in order;
  - are popped with RegWrite=0;
  - never contribute to busy flags.
- Busy flags: busy1 = OR over live (occupied, unkilled) entries of (entry.reg == q_reg1); busy2 likewise for q_reg2. Bypassed results never assert busy.
- Register index 0 has no special treatment; it is written like any other index.
- count:
  - +1 on push without pop;
  - −1 on pop without push;
  - unchanged on simultaneous push and pop;
  - never exceeds DEPTH and never underflows.

Test Plan:
- Reset then idle: after rst_n rises, RegWrite=0, empty=1, lu_ready=1 and busy1=busy2=0 for 10 cycles.
- Bypass: FIFO empty, lu_valid with reg=7, data=0x0000_00A5, no ALU → next posedge RegWrite=1, wreg=7, wdata=0xA5; count stays 0; register file reads 0xA5 from reg 7 after that negedge.
- Priority and fill:
  - hold alu_valid for 6 cycles with regs 1..6 while pushing lu regs 8,9,10,11 (data 0x80..0x83) → ALU writes appear in order 1..6, count reaches 4, full=1 and lu_ready=0;
  - a fifth lu_valid is not accepted;
  - after ALU stops, writes 8,9,10,11 drain on 4 consecutive cycles; then empty=1.
- Kill:
  - queue lu reg=3, data=0x111, then issue ALU reg=3, data=0x222 → register 3 ends holding 0x222;
  - the popped entry shows RegWrite=0;
  - busy for q_reg1=3 drops to 0 in the cycle after the ALU issue.
- Simultaneous same-reg: alu_valid with reg=5, data=0x55 in the same cycle as lu_valid with reg=5, data=0x66 → lu handshake completes, only 0x55 is written, and the killed entry later pops with RegWrite=0.
- Wrap-around and reset mid-operation:
  - push and pop 9 entries with DEPTH=4, interleaved → order is preserved across pointer wrap;
  - assert rst_n low with count=3 → immediately count=0 and RegWrite=0, and none of the queued data is ever written.
